sobol_xor_gen: RTL and testbench

Sobol-sequence update stage that sits directly downstream of the enable/clear index counter in the Sobol RNG. Each enabled cycle it takes the counter's current index n, finds the position of the least-significant zero bit of n, and XORs the selected direction vector into its state register. The result is the Gray-code-ordered Sobol sample x(n+1). A small writable direction-vector file lets one instance serve any dimension; at reset it holds the dimension-1 (van der Corput) vectors.

---
 rtl/sobol_xor_gen_pkg.sv | 13 +
 rtl/sobol_xor_gen_if.sv | 27 ++
 rtl/sobol_xor_gen_lszidx.sv | 21 ++
 rtl/sobol_xor_gen.sv | 72 +++++++
 tb/tb_sobol_xor_gen.sv | 104 ++++++++++
 5 files changed

// File: rtl/sobol_xor_gen_pkg.sv
// Shared Sobol RNG definitions: sample width, direction-vector address width
// and the dimension-1 (van der Corput) default direction vectors.
package sobol_xor_gen_pkg;

  localparam int BITWIDTH = 8;
  localparam int IDXW     = $clog2(BITWIDTH);

  // Direction vector k for dimension 1 at width bw: a single bit walking down from the MSB.
  function automatic logic [31:0] dvDefault(input int bw, input int k);
    return 32'(1) << (bw - 1 - k);
  endfunction

endpackage

// File: rtl/sobol_xor_gen_if.sv
// Sample-advance, clear and direction-vector write bus between the index
// counter side (master) and the Sobol update stage (slave).
interface sobol_xor_gen_if #(
  parameter int BITWIDTH = sobol_xor_gen_pkg::BITWIDTH,
  parameter int IDXW     = $clog2(BITWIDTH)
);

  logic                iEn;
  logic                iClr;
  logic [BITWIDTH-1:0] iCnt;
  logic                iDvWe;
  logic [IDXW-1:0]     iDvAddr;
  logic [BITWIDTH-1:0] iDvData;
  logic [BITWIDTH-1:0] oOut;
  logic                oVld;

  modport master (
    output iEn, iClr, iCnt, iDvWe, iDvAddr, iDvData,
    input  oOut, oVld
  );

  modport slave (
    input  iEn, iClr, iCnt, iDvWe, iDvAddr, iDvData,
    output oOut, oVld
  );

endinterface

// File: rtl/sobol_xor_gen_lszidx.sv
// Least-significant-zero priority encoder; an all-ones index maps to the top
// position so the sequence returns to zero when the counter wraps.
module sobol_xor_gen_lszidx #(
  parameter int BITWIDTH = sobol_xor_gen_pkg::BITWIDTH,
  parameter int IDXW     = $clog2(BITWIDTH)
) (
  input  logic [BITWIDTH-1:0] iCnt,
  output logic [IDXW-1:0]     oIdx
);

  always_comb begin
    oIdx = IDXW'(BITWIDTH - 1);
    // Scan downward so the lowest zero bit wins.
    for (int i = BITWIDTH - 1; i >= 0; i--) begin
      if (!iCnt[i]) begin
        oIdx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/sobol_xor_gen.sv
// Gray-code-ordered Sobol update stage: each enabled cycle XORs the direction
// vector selected by the lowest zero bit of the counter index into the sample.
module sobol_xor_gen
  import sobol_xor_gen_pkg::*;
#(
  parameter int BITWIDTH = sobol_xor_gen_pkg::BITWIDTH,
  parameter int IDXW     = $clog2(BITWIDTH)
) (
  input  logic            iClk,
  input  logic            iRstN,
  sobol_xor_gen_if.slave  bus
);

  logic [BITWIDTH-1:0] stateReg;
  logic [BITWIDTH-1:0] stateNext;
  logic                vldReg;
  logic                vldNext;
  logic [IDXW-1:0]     lszIdx;
  logic [BITWIDTH-1:0] dvQ [BITWIDTH];

  sobol_xor_gen_lszidx #(
    .BITWIDTH (BITWIDTH),
    .IDXW     (IDXW)
  ) uLszIdx (
    .iCnt (bus.iCnt),
    .oIdx (lszIdx)
  );

  // One register per direction vector; an out-of-range address matches no entry.
  genvar gi;
  generate
    for (gi = 0; gi < BITWIDTH; gi++) begin : gDv
      logic [BITWIDTH-1:0] entryReg;

      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
          entryReg <= BITWIDTH'(dvDefault(BITWIDTH, gi));
        end else if (bus.iDvWe && (bus.iDvAddr == IDXW'(gi))) begin
          entryReg <= bus.iDvData;
        end
      end

      assign dvQ[gi] = entryReg;
    end
  endgenerate

  // Clear beats enable; the XOR reads the pre-write vector contents.
  always_comb begin
    stateNext = stateReg;
    vldNext   = 1'b0;
    if (bus.iClr) begin
      stateNext = '0;
    end else if (bus.iEn) begin
      stateNext = stateReg ^ dvQ[lszIdx];
      vldNext   = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateReg <= '0;
      vldReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      vldReg   <= vldNext;
    end
  end

  assign bus.oOut = stateReg;
  assign bus.oVld = vldReg;

endmodule

// File: tb/tb_sobol_xor_gen.sv
// Directed checks of the 4-bit Sobol update stage against hand-computed samples.
module tb_sobol_xor_gen;

  localparam int BW = 4;
  localparam int AW = 2;

  logic iClk = 1'b0;
  logic iRstN = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sobol_xor_gen_if #(.BITWIDTH(BW), .IDXW(AW)) bus ();

  sobol_xor_gen #(.BITWIDTH(BW), .IDXW(AW)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Apply one cycle of inputs at the falling edge, then check just after the rising edge.
  task automatic step(input logic en, input logic clr, input logic [BW-1:0] cnt,
                      input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] data,
                      input logic [BW-1:0] expOut, input logic expVld, input string tag);
    bus.iEn     = en;
    bus.iClr    = clr;
    bus.iCnt    = cnt;
    bus.iDvWe   = we;
    bus.iDvAddr = addr;
    bus.iDvData = data;
    @(posedge iClk);
    #1;
    check({tag, ".out"}, 32'(bus.oOut), 32'(expOut));
    check({tag, ".vld"}, 32'(bus.oVld), 32'(expVld));
    @(negedge iClk);
  endtask

  // Dimension-1 samples x(1)..x(16) from n=0; x(15)=1 since only DV[3] survives n=0..14.
  logic [BW-1:0] seq [16] = '{4'd8, 4'd12, 4'd4, 4'd6, 4'd14, 4'd10, 4'd2, 4'd3,
                              4'd11, 4'd15, 4'd7, 4'd5, 4'd13, 4'd9, 4'd1, 4'd0};

  initial begin
    bus.iEn = 0; bus.iClr = 0; bus.iCnt = '0;
    bus.iDvWe = 0; bus.iDvAddr = '0; bus.iDvData = '0;

    @(negedge iClk);
    check("reset.out", 32'(bus.oOut), 32'd0);
    check("reset.vld", 32'(bus.oVld), 32'd0);
    iRstN = 1'b1;

    // Default sequence then wrap: 16 consecutive enables with the counter value n.
    for (int n = 0; n < 16; n++) begin
      step(1, 0, BW'(n), 0, '0, '0, seq[n], 1'b1, $sformatf("seq.n%0d", n));
    end
    step(0, 0, '0, 0, '0, '0, 4'd0, 1'b0, "idle");

    // Clear priority from S=6.
    for (int n = 0; n < 4; n++) begin
      step(1, 0, BW'(n), 0, '0, '0, seq[n], 1'b1, $sformatf("pre.n%0d", n));
    end
    step(1, 1, 4'd4, 0, '0, '0, 4'd0, 1'b0, "clrPri");
    step(1, 0, 4'd0, 0, '0, '0, 4'd8, 1'b1, "afterClr");

    // DV write collides with an update: old vector used, new one next time.
    step(0, 1, 4'd0, 0, '0, '0, 4'd0, 1'b0, "clrA");
    step(1, 0, 4'd0, 1, 2'd0, 4'd5, 4'd8, 1'b1, "dvColl");
    step(0, 1, 4'd0, 0, '0, '0, 4'd0, 1'b0, "clrB");
    step(1, 0, 4'd0, 0, '0, '0, 4'd5, 1'b1, "dvNew");

    // Asynchronous reset mid-cycle with a pending enable and DV write.
    bus.iEn = 1; bus.iClr = 0; bus.iCnt = 4'd1;
    bus.iDvWe = 1; bus.iDvAddr = 2'd1; bus.iDvData = 4'd3;
    #2 iRstN = 1'b0;
    #1;
    check("asyncRst.out", 32'(bus.oOut), 32'd0);
    check("asyncRst.vld", 32'(bus.oVld), 32'd0);
    @(negedge iClk);
    bus.iEn = 0; bus.iDvWe = 0;
    iRstN = 1'b1;
    step(1, 0, 4'd0, 0, '0, '0, 4'd8, 1'b1, "rstDv0");
    step(1, 0, 4'd1, 0, '0, '0, 4'd12, 1'b1, "rstDv1");

    // Gaps: enable pattern 1,0,0,1; the counter only advances when enabled.
    step(0, 1, 4'd0, 0, '0, '0, 4'd0, 1'b0, "clrC");
    step(1, 0, 4'd0, 0, '0, '0, 4'd8, 1'b1, "gap0");
    step(0, 0, 4'd1, 0, '0, '0, 4'd8, 1'b0, "gap1");
    step(0, 0, 4'd1, 0, '0, '0, 4'd8, 1'b0, "gap2");
    step(1, 0, 4'd1, 0, '0, '0, 4'd12, 1'b1, "gap3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
